// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment-to-binary decoder.
// Segment patterns are stored active-low, bit order g f e d c b a (bit 6 = g).
// When SEG7_ACTIVE_HIGH_EN is defined, the top inverts the captured code once,
// so these constants stay in active-low form in both builds.
package seg7_pkg;

  // Number of decimal digits carried in one 28-bit code word.
  localparam int NUM_DIGITS = 4;

  // Width of one digit's segment pattern.
  localparam int SEG_W = 7;

  // Width of one decoded BCD digit.
  localparam int BCD_W = 4;

  // Active-low digit patterns, g f e d c b a.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Conversion sequence: one cycle per state, digits folded MSB first.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ACC3 = 3'd2,
    ACC2 = 3'd3,
    ACC1 = 3'd4,
    ACC0 = 3'd5,
    DONE = 3'd6
  } state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-low 7-segment pattern to BCD.
// A blank pattern reports blank=1, valid=0 and bcd=0, so blanks fold in as
// zero. Any unrecognised pattern reports valid=0, blank=0 and bcd=0.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [BCD_W-1:0] bcd,
  output logic             valid,
  output logic             blank
);

  // Map each legal pattern to its digit; everything else is flagged invalid.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // the block leaves an output unassigned and no latch is inferred.
    bcd   = '0;
    valid = 1'b1;
    blank = 1'b0;
    case (pattern)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        valid = 1'b0;
        blank = 1'b1;
      end
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_number.sv
// Sequential decoder from a 4-digit 7-segment code back to a binary number.
// A start in IDLE captures the code; the next cycle enters LOAD, which checks
// the digits and clears the accumulator, then ACC3..ACC0 fold one digit per
// cycle (acc = acc*10 + d) and DONE pulses done with the held results.
// Optional build macro: SEG7_ACTIVE_HIGH_EN (code input is active-high; it is
// inverted once at capture so the decoders always see active-low patterns).
module seg7_to_number
  import seg7_pkg::*;
#(
  parameter int RESULT_W = 8,
  parameter int ACC_W    = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_DIGITS*SEG_W-1:0] code,
  output logic                        busy,
  output logic                        done,
  output logic [RESULT_W-1:0]         number,
  output logic                        error,
  output logic                        overflow
);

  // Largest value representable in the result; anything above saturates.
  localparam logic [ACC_W-1:0] SAT = ACC_W'(2**RESULT_W - 1);

  state_t                        state;
  state_t                        state_nxt;

  logic [NUM_DIGITS*SEG_W-1:0]   code_norm;
  logic [NUM_DIGITS*SEG_W-1:0]   code_q;
  logic                          cap_q;
  logic                          accept;

  logic [BCD_W-1:0]              bcd [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]         valid;
  logic [NUM_DIGITS-1:0]         blank;
  logic                          load_err;

  logic [ACC_W-1:0]              acc;
  logic                          err_q;
  logic                          ovf_q;
  logic [BCD_W-1:0]              digit;
  logic [ACC_W-1:0]              acc_next;
  logic [ACC_W-1:0]              acc_fold;
  logic                          ovf_fold;

  // Bring the input to active-low once so the decoders need only one table.
`ifdef SEG7_ACTIVE_HIGH_EN
  assign code_norm = ~code;
`else
  assign code_norm = code;
`endif

  // A request is taken only from a truly idle block: not mid-conversion and
  // not in the capture cycle that precedes LOAD.
  assign accept = (state == IDLE) && !cap_q && start;

  // One decoder per digit; digit 0 is the ones position in the low bits.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gen_dec
    seg7_digit_decode u_dec (
      .pattern (code_q[i*SEG_W +: SEG_W]),
      .bcd     (bcd[i]),
      .valid   (valid[i]),
      .blank   (blank[i])
    );
  end

  // Validate the captured word: bad patterns, a blank ones digit, or a blank
  // below a non-blank digit (only leading blanks are legal).
  always_comb begin
    logic seen_digit;
    load_err   = 1'b0;
    seen_digit = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (!valid[i] && !blank[i]) load_err = 1'b1;
      if (blank[i] && seen_digit) load_err = 1'b1;
      if (!blank[i])              seen_digit = 1'b1;
    end
    if (blank[0]) load_err = 1'b1;
  end

  // Pick the digit folded in this cycle, most significant first.
  always_comb begin
    digit = '0;
    case (state)
      ACC3:    digit = bcd[3];
      ACC2:    digit = bcd[2];
      ACC1:    digit = bcd[1];
      ACC0:    digit = bcd[0];
      default: digit = '0;
    endcase
  end

  // acc*10 + d as two shifts and adds; also the post-fold accumulator and
  // sticky overflow, shared by the accumulator update and the DONE results.
  always_comb begin
    acc_next = {acc[ACC_W-4:0], 3'b000}
             + {acc[ACC_W-2:0], 1'b0}
             + {{(ACC_W-BCD_W){1'b0}}, digit};
    ovf_fold = ovf_q || (acc_next > SAT);
    acc_fold = ovf_q ? acc : acc_next;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state sequencing: a captured request starts LOAD, then one cycle each.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cap_q) state_nxt = LOAD;
      LOAD:    state_nxt = ACC3;
      ACC3:    state_nxt = ACC2;
      ACC2:    state_nxt = ACC1;
      ACC1:    state_nxt = ACC0;
      ACC0:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture register: the code is frozen here until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q  <= 1'b0;
      code_q <= '0;
    end else begin
      cap_q <= accept;
      if (accept) code_q <= code_norm;
    end
  end

  // Accumulator and sticky flags: cleared in LOAD, frozen once overflowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          acc   <= '0;
          err_q <= load_err;
          ovf_q <= 1'b0;
        end
        ACC3, ACC2, ACC1, ACC0: begin
          acc   <= acc_fold;
          ovf_q <= ovf_fold;
        end
        default: ;
      endcase
    end
  end

  // Result registers: written only on the transition into DONE, so they are
  // valid alongside done and held until the next conversion finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      number   <= '0;
      error    <= 1'b0;
      overflow <= 1'b0;
    end else if (state == ACC0) begin
      if (err_q) begin
        number   <= '0;
        error    <= 1'b1;
        overflow <= 1'b0;
      end else if (ovf_fold) begin
        number   <= '1;
        error    <= 1'b0;
        overflow <= 1'b1;
      end else begin
        number   <= acc_fold[RESULT_W-1:0];
        error    <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
